dcache_controller: RTL

Direct-mapped, write-through, no-write-allocate data cache with its miss/stall FSM. It sits directly downstream of the core's control decoder and consumes that decoder's `MemRead`/`MemWrite` strobes together with the ALU address and store data. It returns load data and a `Stall` that freezes the PC and register-file writes, and it runs a req/ready handshake to main memory.

---
 rtl/dcache_controller_if.sv | 30 +++
 rtl/dcache_controller.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dcache_controller_if.sv
// Core-side and memory-side signal bundle for dcache_controller.
// slave = the cache itself, master = the core/memory environment driving it.
interface dcache_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  Stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  MemRead, MemWrite, addr, wdata, mem_rdata, mem_ready,
    output rdata, Stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output MemRead, MemWrite, addr, wdata, mem_rdata, mem_ready,
    input  rdata, Stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with miss/stall FSM.
// Optional read-hit/read-miss/store counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       write_count
`endif
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WR_THRU = 2'd2;
  localparam logic [1:0] WR_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_ram  [LINES];
  logic [DATA_WIDTH-1:0] data_ram [LINES];
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  hit;
  logic                  refill;
  logic                  wr_update;
  logic                  unused_addr_bits;

  // Outside IDLE the core address may not be trusted, so look up the captured request.
  assign lk_addr  = (state_q == IDLE) ? bus.addr : mem_addr_q;
  assign lk_index = lk_addr[INDEX_BITS+1:2];
  assign lk_tag   = lk_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit      = valid_q[lk_index] && (tag_ram[lk_index] == lk_tag);
  assign unused_addr_bits = ^{lk_addr[1:0], bus.addr[1:0]};

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    refill      = 1'b0;
    wr_update   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MemWrite) begin
          state_d     = WR_THRU;
          mem_addr_d  = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = bus.wdata;
        end else if (bus.MemRead && !hit) begin
          state_d    = RD_MISS;
          mem_addr_d = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
        end
      end
      RD_MISS: begin
        if (bus.mem_ready) begin
          refill  = 1'b1;
          state_d = IDLE;
        end
      end
      WR_THRU: begin
        if (bus.mem_ready) begin
          wr_update = hit;
          state_d   = WR_DONE;
        end
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (refill) valid_q[lk_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill) begin
      data_ram[lk_index] <= bus.mem_rdata;
      tag_ram[lk_index]  <= lk_tag;
    end else if (wr_update) begin
      data_ram[lk_index] <= mem_wdata_q;
    end
  end

  assign bus.rdata     = data_ram[bus.addr[INDEX_BITS+1:2]];
  assign bus.mem_req   = (state_q == RD_MISS) || (state_q == WR_THRU);
  assign bus.mem_we    = (state_q == WR_THRU);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.Stall     = (state_q == RD_MISS) || (state_q == WR_THRU) ||
                         ((state_q == IDLE) && (bus.MemWrite || (bus.MemRead && !hit)));

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, miss_q, write_q;
  logic        prev_miss_q;

  // The post-refill retry hits too, but it belongs to the miss already counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= '0;
      miss_q      <= '0;
      write_q     <= '0;
      prev_miss_q <= 1'b0;
    end else begin
      prev_miss_q <= (state_q == RD_MISS);
      if ((state_q == IDLE) && (state_d == RD_MISS)) miss_q <= miss_q + 32'd1;
      if ((state_q == WR_THRU) && (state_d == WR_DONE)) write_q <= write_q + 32'd1;
      if ((state_q == IDLE) && bus.MemRead && hit && !bus.MemWrite && !prev_miss_q)
        hit_q <= hit_q + 32'd1;
    end
  end

  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign write_count = write_q;
`endif
endmodule
